// File: rtl/dsp_nco_sweep_ctrl_if.sv
// dsp_nco_sweep_ctrl_if: sweep descriptor valid/ready channel into dsp_nco_sweep_ctrl
//   cfg_valid/cfg_ready  handshake, transfer when both high
//   cfg_f_start          first FCW of the sweep
//   cfg_f_step           FCW increment per step, two's complement
//   cfg_n_steps          number of increments (n_steps+1 frequencies)
//   cfg_dwell            each frequency held dwell+1 cycles
//   cfg_repeat           1: loop until abort, 0: one-shot
interface dsp_nco_sweep_ctrl_if #(
  parameter int PHI_WIDTH   = 32,
  parameter int STEP_WIDTH  = 16,
  parameter int DWELL_WIDTH = 16
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PHI_WIDTH-1:0]   cfg_f_start;
  logic [PHI_WIDTH-1:0]   cfg_f_step;
  logic [STEP_WIDTH-1:0]  cfg_n_steps;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   cfg_repeat;
  modport master (output cfg_valid, cfg_f_start, cfg_f_step, cfg_n_steps, cfg_dwell, cfg_repeat, input cfg_ready);
  modport slave  (input cfg_valid, cfg_f_start, cfg_f_step, cfg_n_steps, cfg_dwell, cfg_repeat, output cfg_ready);
endinterface

// File: rtl/dsp_nco_sweep_ctrl.sv
// dsp_nco_sweep_ctrl: steps dsp_nco.en/phi_inc through a programmed linear frequency sweep
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg          descriptor channel (slave), accepted only while idle
//   start        launches an armed sweep; abort ends/discards immediately
//   busy         controller not idle
//   nco_en       to dsp_nco.en (low clears the NCO phase)
//   nco_phi_inc  to dsp_nco.phi_inc
//   step_pulse   one cycle with each FCW change after the first
//   done         one cycle when a one-shot sweep completes
// Define DSP_NCO_SWEEP_PINGPONG_EN for triangle (direction-reversing) repeat sweeps;
// by default a repeating sweep reloads f_start (sawtooth).
module dsp_nco_sweep_ctrl #(
  parameter int PHI_WIDTH   = 32,
  parameter int STEP_WIDTH  = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dsp_nco_sweep_ctrl_if.slave  cfg,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 nco_en,
  output logic [PHI_WIDTH-1:0] nco_phi_inc,
  output logic                 step_pulse,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t                 state, state_nx;
  logic [PHI_WIDTH-1:0]   f_start, f_step, phi_nx, inc;
  logic [STEP_WIDTH-1:0]  n_steps, step_cnt, step_nx;
  logic [DWELL_WIDTH-1:0] dwell, dwell_cnt, dwell_nx;
  logic                   rpt, dir, dir_nx, en_nx, pulse_nx, done_nx, load;
  assign cfg.cfg_ready = state == IDLE;
  assign busy          = state != IDLE;
  assign load          = cfg.cfg_valid && state == IDLE;
  // dir is only ever set in the ping-pong build; it flips the step sign on each wrap
  assign inc           = dir ? -f_step : f_step;
  always_comb begin
    state_nx = state;
    en_nx    = nco_en;
    phi_nx   = nco_phi_inc;
    pulse_nx = 1'b0;
    done_nx  = 1'b0;
    dwell_nx = dwell_cnt;
    step_nx  = step_cnt;
    dir_nx   = dir;
    case (state)
      IDLE: state_nx = cfg.cfg_valid ? ARMED : IDLE;
      ARMED:
        if (abort) state_nx = IDLE;
        else if (start) begin
          state_nx = RUN;
          en_nx    = 1'b1;
          phi_nx   = f_start;
          dwell_nx = dwell;
          step_nx  = '0;
          dir_nx   = 1'b0;
        end
      RUN:
        if (abort) begin
          state_nx = IDLE;
          en_nx    = 1'b0;
          phi_nx   = '0;
        end else if (dwell_cnt != '0) dwell_nx = dwell_cnt - DWELL_WIDTH'(1);
        else if (step_cnt < n_steps) begin
          phi_nx   = nco_phi_inc + inc;
          step_nx  = step_cnt + STEP_WIDTH'(1);
          dwell_nx = dwell;
          pulse_nx = 1'b1;
        end else if (rpt) begin
          step_nx  = '0;
          dwell_nx = dwell;
          pulse_nx = 1'b1;
`ifdef DSP_NCO_SWEEP_PINGPONG_EN
          dir_nx   = ~dir;
`else
          phi_nx   = f_start;
`endif
        end else begin
          state_nx = IDLE;
          en_nx    = 1'b0;
          phi_nx   = '0;
          done_nx  = 1'b1;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      nco_en      <= 1'b0;
      nco_phi_inc <= '0;
      step_pulse  <= 1'b0;
      done        <= 1'b0;
      dwell_cnt   <= '0;
      step_cnt    <= '0;
      dir         <= 1'b0;
      f_start     <= '0;
      f_step      <= '0;
      n_steps     <= '0;
      dwell       <= '0;
      rpt         <= 1'b0;
    end else begin
      state       <= state_nx;
      nco_en      <= en_nx;
      nco_phi_inc <= phi_nx;
      step_pulse  <= pulse_nx;
      done        <= done_nx;
      dwell_cnt   <= dwell_nx;
      step_cnt    <= step_nx;
      dir         <= dir_nx;
      if (load) begin
        f_start <= cfg.cfg_f_start;
        f_step  <= cfg.cfg_f_step;
        n_steps <= cfg.cfg_n_steps;
        dwell   <= cfg.cfg_dwell;
        rpt     <= cfg.cfg_repeat;
      end
    end
endmodule
